// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-master bus arbiter
package rexta;

  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_RESP} arb_state_t;

  // Must decode to no slave on system_bus.
  localparam logic [31:0] BUS_IDLE_ADDR = 32'hFFFF_FFFF;

  typedef logic [0:0] master_id_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side and system-bus-side signals of the arbiter
interface bus_arbiter_if;

  logic        m0_req;
  logic        m1_req;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic        m0_we;
  logic        m1_we;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic        m0_ready;
  logic        m1_ready;
  logic        m0_err;
  logic        m1_err;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [1:0]  grant;

  // Arbiter side: serves the masters and drives the system bus.
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata,
    input  bus_rdata, bus_ready,
    output m0_ready, m1_ready, m0_err, m1_err, m0_rdata, m1_rdata,
    output bus_addr, bus_we, bus_wdata, grant
  );

  // Environment side: the bus masters plus the system bus slave.
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata,
    output bus_rdata, bus_ready,
    input  m0_ready, m1_ready, m0_err, m1_err, m0_rdata, m1_rdata,
    input  bus_addr, bus_we, bus_wdata, grant
  );

endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// rtl/bus_arbiter_rr_pick2.sv - combinational two-way round-robin selector
module rr_pick2
  import rexta::*;
(
  input  logic [1:0] req,
  input  master_id_t last,
  output master_id_t winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = master_id_t'(1'b0);
    case (req)
      2'b01:   winner = master_id_t'(1'b0);
      2'b10:   winner = master_id_t'(1'b1);
      2'b11:   winner = ~last;
      default: winner = master_id_t'(1'b0);
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master arbiter in front of system_bus
module bus_arbiter
  import rexta::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] IDLE_ADDR      = rexta::BUS_IDLE_ADDR
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave arb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state_q, state_d;
  master_id_t       last_q, last_d;
  master_id_t       owner_q, owner_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;

  master_id_t pick_winner;
  logic       pick_valid;

  rr_pick2 u_pick (
    .req    ({arb.m1_req, arb.m0_req}),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    ready_d     = 2'b00;
    err_d       = 2'b00;
    rdata0_d    = '0;
    rdata1_d    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_winner;
          last_d      = pick_winner;
          grant_d     = 2'b01 << pick_winner;
          cnt_d       = '0;
          bus_addr_d  = pick_winner[0] ? arb.m1_addr  : arb.m0_addr;
          bus_we_d    = pick_winner[0] ? arb.m1_we    : arb.m0_we;
          bus_wdata_d = pick_winner[0] ? arb.m1_wdata : arb.m0_wdata;
          state_d     = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // bus_ready wins over an abort landing in the same cycle.
        if (arb.bus_ready || (cnt_q == CNT_LAST)) begin
          ready_d[owner_q] = 1'b1;
          err_d[owner_q]   = ~arb.bus_ready;
          if (arb.bus_ready) begin
            if (owner_q[0]) rdata1_d = arb.bus_rdata;
            else            rdata0_d = arb.bus_rdata;
          end
          bus_addr_d = IDLE_ADDR;
          bus_we_d   = 1'b0;
          state_d    = ARB_RESP;
        end
      end
      ARB_RESP: begin
        grant_d = 2'b00;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      last_q      <= master_id_t'(1'b1);
      owner_q     <= master_id_t'(1'b0);
      grant_q     <= 2'b00;
      cnt_q       <= '0;
      bus_addr_q  <= IDLE_ADDR;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      ready_q     <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign arb.m0_ready  = ready_q[0];
  assign arb.m1_ready  = ready_q[1];
  assign arb.m0_err    = err_q[0];
  assign arb.m1_err    = err_q[1];
  assign arb.m0_rdata  = rdata0_q;
  assign arb.m1_rdata  = rdata1_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.grant     = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with directed vectors
module tb_bus_arbiter;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  bus_arbiter_if bif();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] rd, input logic err);
    exp_t e;
    e.id = id;
    e.rdata = rd;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (bif.m0_ready || bif.m1_ready) begin
      automatic exp_t e;
      automatic int   id = bif.m1_ready ? 1 : 0;
      chk("mon_both_ready", 32'(bif.m0_ready & bif.m1_ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected_ready m0_ready=%0b m1_ready=%0b required=none", bif.m0_ready, bif.m1_ready);
      end else begin
        e = sb.pop_front();
        chk("mon_id", 32'(id), 32'(e.id));
        chk("mon_rdata", id ? bif.m1_rdata : bif.m0_rdata, e.rdata);
        chk("mon_err", 32'(id ? bif.m1_err : bif.m0_err), 32'(e.err));
        chk("mon_other_rdata", id ? bif.m0_rdata : bif.m1_rdata, 32'd0);
        chk("mon_other_err", 32'(id ? bif.m0_err : bif.m1_err), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bif.m0_req = 1'b0;  bif.m1_req = 1'b0;
    bif.m0_addr = '0;   bif.m1_addr = '0;
    bif.m0_we = 1'b0;   bif.m1_we = 1'b0;
    bif.m0_wdata = '0;  bif.m1_wdata = '0;
    bif.bus_rdata = '0; bif.bus_ready = 1'b0;
    repeat (3) step();

    chk("rst_bus_addr", bif.bus_addr, 32'hFFFF_FFFF);
    chk("rst_bus_we", 32'(bif.bus_we), 32'd0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'd0);
    chk("rst_grant", 32'(bif.grant), 32'd0);
    chk("rst_ready", 32'({bif.m1_ready, bif.m0_ready, bif.m1_err, bif.m0_err}), 32'd0);
    chk("rst_rdata", bif.m0_rdata | bif.m1_rdata, 32'd0);
    reset = 1'b0;
    step();

    // Single read by m0, slave ready in the 2nd XFER cycle.
    bif.m0_req = 1'b1; bif.m0_addr = 32'h10; bif.m0_we = 1'b0;
    step();
    chk("rd_addr_c1", bif.bus_addr, 32'h10);
    chk("rd_grant_c1", 32'(bif.grant), 32'd1);
    chk("rd_we_c1", 32'(bif.bus_we), 32'd0);
    step();
    chk("rd_addr_c2", bif.bus_addr, 32'h10);
    chk("rd_ready_c2", 32'(bif.m0_ready), 32'd0);
    bif.bus_ready = 1'b1; bif.bus_rdata = 32'h1234_5678;
    expect_rsp(0, 32'h1234_5678, 1'b0);
    step();
    bif.bus_ready = 1'b0; bif.m0_req = 1'b0;
    chk("rd_ready_c3", 32'(bif.m0_ready), 32'd1);
    chk("rd_idle_addr_c3", bif.bus_addr, 32'hFFFF_FFFF);
    step();
    chk("rd_ready_c4", 32'(bif.m0_ready), 32'd0);

    // Write window by m1, ready in the 3rd XFER cycle.
    bif.m1_req = 1'b1; bif.m1_addr = 32'h8000_0000; bif.m1_we = 1'b1; bif.m1_wdata = 32'hA5;
    bif.bus_rdata = 32'hDEAD_BEEF;
    step();
    chk("wr_addr_c1", bif.bus_addr, 32'h8000_0000);
    chk("wr_wdata_c1", bif.bus_wdata, 32'hA5);
    chk("wr_grant_c1", 32'(bif.grant), 32'd2);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("wr_we_c%0d", i), 32'(bif.bus_we), 32'd1);
      if (i == 3) begin
        bif.bus_ready = 1'b1;
        expect_rsp(1, 32'hDEAD_BEEF, 1'b0);
      end
      step();
    end
    bif.bus_ready = 1'b0; bif.m1_req = 1'b0; bif.m1_we = 1'b0;
    chk("wr_we_resp", 32'(bif.bus_we), 32'd0);
    chk("wr_m1_ready", 32'(bif.m1_ready), 32'd1);
    chk("wr_m0_ready", 32'(bif.m0_ready), 32'd0);
    step();

    // Contention from reset release with a 1-cycle slave.
    reset = 1'b1;
    bif.m0_req = 1'b1; bif.m0_addr = 32'h100;
    bif.m1_req = 1'b1; bif.m1_addr = 32'h200;
    bif.bus_ready = 1'b1; bif.bus_rdata = 32'hC0FF_EE00;
    step();
    reset = 1'b0;
    chk("cont_grant_c0", 32'(bif.grant), 32'd0);
    for (int i = 0; i < 4; i++) begin
      automatic int w = i % 2;
      step();
      chk($sformatf("cont_grant_%0d", i), 32'(bif.grant), w ? 32'd2 : 32'd1);
      chk($sformatf("cont_addr_%0d", i), bif.bus_addr, w ? 32'h200 : 32'h100);
      expect_rsp(w, 32'hC0FF_EE00, 1'b0);
      step();
      chk($sformatf("cont_ready_%0d", i), 32'({bif.m1_ready, bif.m0_ready}), w ? 32'd2 : 32'd1);
      if (i == 3) begin
        bif.m0_req = 1'b0; bif.m1_req = 1'b0; bif.bus_ready = 1'b0;
      end
      step();
    end

    // Timeout with TIMEOUT_CYCLES=4, then ready arriving in the 4th XFER cycle.
    bif.m1_req = 1'b1; bif.m1_addr = 32'h300; bif.bus_rdata = 32'h77;
    expect_rsp(1, 32'd0, 1'b1);
    repeat (4) step();
    chk("to_ready_c4", 32'(bif.m1_ready), 32'd0);
    step();
    chk("to_ready_c5", 32'(bif.m1_ready), 32'd1);
    chk("to_err_c5", 32'(bif.m1_err), 32'd1);
    bif.m1_req = 1'b0;
    step();
    bif.m1_req = 1'b1; bif.m1_addr = 32'h304;
    repeat (4) step();
    bif.bus_ready = 1'b1; bif.bus_rdata = 32'h0BAD_F00D;
    expect_rsp(1, 32'h0BAD_F00D, 1'b0);
    step();
    bif.bus_ready = 1'b0; bif.m1_req = 1'b0;
    chk("to_late_ready", 32'(bif.m1_ready), 32'd1);
    chk("to_late_err", 32'(bif.m1_err), 32'd0);
    step();

    // Reset in the 2nd XFER cycle of an m1 write.
    bif.m1_req = 1'b1; bif.m1_addr = 32'h400; bif.m1_we = 1'b1; bif.m1_wdata = 32'h99;
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_addr", bif.bus_addr, 32'hFFFF_FFFF);
    chk("mid_rst_we", 32'(bif.bus_we), 32'd0);
    chk("mid_rst_wdata", bif.bus_wdata, 32'd0);
    chk("mid_rst_grant", 32'(bif.grant), 32'd0);
    chk("mid_rst_m1_ready", 32'(bif.m1_ready), 32'd0);
    reset = 1'b0; bif.m1_req = 1'b0; bif.m1_we = 1'b0;
    step();
    chk("mid_rst_m1_ready_after", 32'(bif.m1_ready), 32'd0);
    bif.m0_req = 1'b1; bif.m0_addr = 32'h500;
    bif.m1_req = 1'b1; bif.m1_addr = 32'h600;
    bif.bus_ready = 1'b1; bif.bus_rdata = 32'h5A5A_5A5A;
    step();
    chk("mid_rst_tie_grant", 32'(bif.grant), 32'd1);
    chk("mid_rst_tie_addr", bif.bus_addr, 32'h500);
    expect_rsp(0, 32'h5A5A_5A5A, 1'b0);
    bif.m1_req = 1'b0;
    step();
    chk("mid_rst_tie_ready", 32'(bif.m0_ready), 32'd1);
    bif.m0_req = 1'b0; bif.bus_ready = 1'b0;
    step();

    // Latching: m0 changes inputs and drops req during XFER.
    bif.m0_req = 1'b1; bif.m0_addr = 32'h40; bif.m0_we = 1'b1; bif.m0_wdata = 32'h11;
    step();
    chk("latch_addr_c1", bif.bus_addr, 32'h40);
    chk("latch_wdata_c1", bif.bus_wdata, 32'h11);
    bif.m0_addr = 32'h44; bif.m0_wdata = 32'h22; bif.m0_req = 1'b0; bif.m0_we = 1'b0;
    step();
    chk("latch_addr_c2", bif.bus_addr, 32'h40);
    chk("latch_wdata_c2", bif.bus_wdata, 32'h11);
    chk("latch_we_c2", 32'(bif.bus_we), 32'd1);
    bif.bus_ready = 1'b1; bif.bus_rdata = 32'h33;
    expect_rsp(0, 32'h33, 1'b0);
    step();
    bif.bus_ready = 1'b0;
    chk("latch_ready_c3", 32'(bif.m0_ready), 32'd1);
    step();
    step();
    chk("latch_idle_grant", 32'(bif.grant), 32'd0);
    chk("latch_idle_addr", bif.bus_addr, 32'hFFFF_FFFF);

    repeat (3) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
